// File: rtl/oc_guard_pkg.sv
// Shared types and helpers for the overcurrent guard: channel state encoding and
// counter-width sizing.
package oc_guard_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StTrip = 2'd1,
    StLock = 2'd2
  } oc_state_e;

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/oc_channel.sv
// One motor channel: OC synchronizer, glitch filter, RUN/TRIP/LOCK state machine with
// retry accounting, and the gated PWM enable.
module oc_channel
  import oc_guard_pkg::*;
#(
  parameter int unsigned OcFilt   = 16,
  parameter int unsigned CoolCyc  = 1_000_000,
  parameter int unsigned MaxRetry = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic oc_i,
  input  logic clr_i,
  input  logic pwm_on_i,
  output logic en_o,
  output logic tripped_o,
  output logic locked_o,
  output logic fault_d_o
);

  localparam int unsigned FiltW  = cnt_width(OcFilt);
  localparam int unsigned CycW   = $clog2(CoolCyc + 1);
  localparam int unsigned RetryW = cnt_width(MaxRetry);

  localparam logic [FiltW-1:0]  FiltMax  = FiltW'(OcFilt);
  localparam logic [CycW-1:0]   CycMax   = CycW'(CoolCyc);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetry);

  oc_state_e         state_q, state_d;
  logic              oc_meta_q, oc_sync_q;
  logic [FiltW-1:0]  filt_q, filt_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              en_q, tripped_q, locked_q;

  always_comb begin
    state_d = state_q;
    filt_d  = '0;
    cyc_d   = cyc_q;
    retry_d = retry_q;
    unique case (state_q)
      StRun: begin
        if (oc_sync_q) begin
          filt_d = (filt_q == FiltMax) ? filt_q : filt_q + 1'b1;
          // Any overcurrent sample restarts the clean-run window.
          cyc_d  = '0;
          if (filt_d == FiltMax) begin
            state_d = StTrip;
            retry_d = (retry_q == RetryMax) ? retry_q : retry_q + 1'b1;
          end
        end else if (cyc_q != CycMax) begin
          cyc_d = cyc_q + 1'b1;
          if (cyc_d == CycMax) begin
            retry_d = '0;
          end
        end
      end
      StTrip: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_d == CycMax) begin
          cyc_d   = '0;
          state_d = (retry_q == RetryMax) ? StLock : StRun;
        end
      end
      StLock: begin
        if (clr_i) begin
          state_d = StRun;
          retry_d = '0;
          cyc_d   = '0;
        end
      end
      default: begin
        state_d = StRun;
        cyc_d   = '0;
        retry_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StRun;
      oc_meta_q <= 1'b0;
      oc_sync_q <= 1'b0;
      filt_q    <= '0;
      cyc_q     <= '0;
      retry_q   <= '0;
      en_q      <= 1'b0;
      tripped_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      oc_meta_q <= oc_i;
      oc_sync_q <= oc_meta_q;
      filt_q    <= filt_d;
      cyc_q     <= cyc_d;
      retry_q   <= retry_d;
      en_q      <= (state_d == StRun) && pwm_on_i;
      tripped_q <= (state_d == StTrip);
      locked_q  <= (state_d == StLock);
    end
  end

  assign en_o      = en_q;
  assign tripped_o = tripped_q;
  assign locked_o  = locked_q;
  // Next-state fault lets the top register fault_any in step with tripped/locked.
  assign fault_d_o = (state_d != StRun);

endmodule

// File: rtl/oc_guard.sv
// Multi-channel motor overcurrent guard: shared PWM counter, per-channel protection
// channels, and a global fault flag.
module oc_guard
  import oc_guard_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned DUTY_W    = 8,
  parameter int unsigned OC_FILT   = 16,
  parameter int unsigned COOL_CYC  = 1_000_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                     CLK100MHZ,
  input  logic                     rst_n,
  input  logic [N_CH*DUTY_W-1:0]   duty,
  input  logic [N_CH-1:0]          OC,
  input  logic [N_CH-1:0]          clr,
  output logic [N_CH-1:0]          EN,
  output logic [N_CH-1:0]          tripped,
  output logic [N_CH-1:0]          locked,
  output logic                     fault_any
);

  logic [DUTY_W-1:0] pwm_cnt_q;
  logic [N_CH-1:0]   fault_d;
  logic              fault_any_q;

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      pwm_cnt_q   <= '0;
      fault_any_q <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_q + 1'b1;
      fault_any_q <= |fault_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic pwm_on;
    assign pwm_on = (pwm_cnt_q < duty[i*DUTY_W +: DUTY_W]);

    oc_channel #(
      .OcFilt   (OC_FILT),
      .CoolCyc  (COOL_CYC),
      .MaxRetry (MAX_RETRY)
    ) u_ch (
      .clk_i     (CLK100MHZ),
      .rst_ni    (rst_n),
      .oc_i      (OC[i]),
      .clr_i     (clr[i]),
      .pwm_on_i  (pwm_on),
      .en_o      (EN[i]),
      .tripped_o (tripped[i]),
      .locked_o  (locked[i]),
      .fault_d_o (fault_d[i])
    );
  end

  assign fault_any = fault_any_q;

endmodule

// File: tb/tb_oc_guard.sv
// Directed bench for oc_guard with a small PWM reference model; each scenario task
// drives stimulus and checks outputs inline.
module tb_oc_guard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] duty;
  logic [1:0] oc;
  logic [1:0] clr;
  logic [1:0] en;
  logic [1:0] tripped;
  logic [1:0] locked;
  logic       fault_any;

  int   errors = 0;
  int   checks = 0;
  int   pwm_m  = 0;
  logic on0    = 1'b0;
  logic on1    = 1'b0;

  always #5 clk = ~clk;

  oc_guard #(
    .N_CH      (2),
    .DUTY_W    (4),
    .OC_FILT   (4),
    .COOL_CYC  (20),
    .MAX_RETRY (2)
  ) dut (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .duty      (duty),
    .OC        (oc),
    .clr       (clr),
    .EN        (en),
    .tripped   (tripped),
    .locked    (locked),
    .fault_any (fault_any)
  );

  // Advance one edge; on0/on1 give the PWM phase the DUT registered on that edge.
  task automatic tick();
    if (!rst_n) begin
      pwm_m = 0;
      on0   = 1'b0;
      on1   = 1'b0;
    end else begin
      on0   = (pwm_m < int'(duty[3:0]));
      on1   = (pwm_m < int'(duty[7:4]));
      pwm_m = (pwm_m + 1) % 16;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    duty  = 8'h08;
    oc    = 2'b11;
    clr   = 2'b00;
    tick();
    tick();
    oc = 2'b00;
    tick();
    checks++; if (en !== 2'b00) begin
      $display("FAIL reset_en: got %b want 00", en); errors++; end
    checks++; if (tripped !== 2'b00) begin
      $display("FAIL reset_tripped: got %b want 00", tripped); errors++; end
    checks++; if (locked !== 2'b00) begin
      $display("FAIL reset_locked: got %b want 00", locked); errors++; end
    checks++; if (fault_any !== 1'b0) begin
      $display("FAIL reset_fault_any: got %b want 0", fault_any); errors++; end
  endtask

  task automatic test_pwm();
    int ones = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k >= 16 && en[0]) ones++;
      checks++; if (en[0] !== on0) begin
        $display("FAIL pwm_en0 cyc %0d: got %b want %b", k, en[0], on0); errors++; end
      checks++; if (en[1] !== 1'b0) begin
        $display("FAIL pwm_en1_zero cyc %0d: got %b want 0", k, en[1]); errors++; end
      checks++; if (fault_any !== 1'b0) begin
        $display("FAIL pwm_fault_any cyc %0d: got %b want 0", k, fault_any); errors++; end
    end
    checks++; if (ones != 8) begin
      $display("FAIL pwm_on_count_8: got %0d want 8", ones); errors++; end
  endtask

  task automatic test_duty_max();
    int ones = 0;
    duty[3:0] = 4'hf;
    tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      if (en[0]) ones++;
    end
    checks++; if (ones != 15) begin
      $display("FAIL duty_max_on_count: got %0d want 15", ones); errors++; end
    duty = 8'h58;
    tick();
  endtask

  task automatic test_short_pulse();
    oc[0] = 1'b1;
    for (int k = 0; k < 23; k++) begin
      if (k == 3) oc[0] = 1'b0;
      tick();
      checks++; if (en[0] !== on0) begin
        $display("FAIL short_pulse_en0 cyc %0d: got %b want %b", k, en[0], on0); errors++; end
      checks++; if (tripped[0] !== 1'b0) begin
        $display("FAIL short_pulse_trip cyc %0d: got %b want 0", k, tripped[0]); errors++; end
    end
  endtask

  // One trip from a clean RUN state: trip lands 6 edges after the pin rises, lasts 20.
  task automatic trip_once(input string tag);
    logic exp_trip;
    oc[0] = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      if (k == 7) oc[0] = 1'b0;
      tick();
      exp_trip = (k >= 6 && k <= 25);
      checks++; if (tripped[0] !== exp_trip) begin
        $display("FAIL %s_tripped k=%0d: got %b want %b", tag, k, tripped[0], exp_trip);
        errors++; end
      checks++; if (en[0] !== (on0 & ~exp_trip)) begin
        $display("FAIL %s_en0 k=%0d: got %b want %b", tag, k, en[0], on0 & ~exp_trip);
        errors++; end
      checks++; if (en[1] !== on1) begin
        $display("FAIL %s_en1_indep k=%0d: got %b want %b", tag, k, en[1], on1); errors++; end
      checks++; if (fault_any !== exp_trip) begin
        $display("FAIL %s_fault_any k=%0d: got %b want %b", tag, k, fault_any, exp_trip);
        errors++; end
      checks++; if (locked[0] !== 1'b0) begin
        $display("FAIL %s_locked k=%0d: got %b want 0", tag, k, locked[0]); errors++; end
    end
  endtask

  task automatic test_trip();
    trip_once("trip");
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++; if (en[0] !== on0) begin
        $display("FAIL trip_resume_en0 cyc %0d: got %b want %b", k, en[0], on0); errors++; end
    end
  endtask

  task automatic test_retry_clear();
    repeat (10) tick();
    trip_once("retry_clear");
  endtask

  // Continuous overcurrent from retry=0: trips at 6 and 30, lock at 50.
  task automatic lock_up(input string tag, input logic poke_clr);
    logic exp_trip, exp_lock;
    oc[0] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      clr[0] = poke_clr && (k == 36);
      tick();
      exp_trip = (k >= 6 && k <= 25) || (k >= 30 && k <= 49);
      exp_lock = (k == 50);
      checks++; if (tripped[0] !== exp_trip) begin
        $display("FAIL %s_tripped k=%0d: got %b want %b", tag, k, tripped[0], exp_trip);
        errors++; end
      checks++; if (locked[0] !== exp_lock) begin
        $display("FAIL %s_locked k=%0d: got %b want %b", tag, k, locked[0], exp_lock);
        errors++; end
    end
    clr[0] = 1'b0;
  endtask

  task automatic test_lock();
    repeat (25) tick();
    lock_up("lock", 1'b1);
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++; if (locked[0] !== 1'b1 || en[0] !== 1'b0 || fault_any !== 1'b1) begin
        $display("FAIL lock_hold cyc %0d: got locked=%b en0=%b fault=%b want 1 0 1",
                 k, locked[0], en[0], fault_any);
        errors++; end
      checks++; if (en[1] !== on1) begin
        $display("FAIL lock_en1_indep cyc %0d: got %b want %b", k, en[1], on1); errors++; end
    end
    // clr arrives while the synchronized OC is still high.
    clr[0] = 1'b1;
    oc[0]  = 1'b0;
    tick();
    clr[0] = 1'b0;
    checks++; if (locked[0] !== 1'b0 || tripped[0] !== 1'b0 || fault_any !== 1'b0) begin
      $display("FAIL clr_release: got locked=%b tripped=%b fault=%b want 0 0 0",
               locked[0], tripped[0], fault_any);
      errors++; end
    checks++; if (en[0] !== on0) begin
      $display("FAIL clr_release_en0: got %b want %b", en[0], on0); errors++; end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++; if (en[0] !== on0 || tripped[0] !== 1'b0) begin
        $display("FAIL clr_pwm_restored cyc %0d: got en0=%b tripped=%b want %b 0",
                 k, en[0], tripped[0], on0);
        errors++; end
    end
  endtask

  task automatic test_reset_in_lock();
    lock_up("relock", 1'b0);
    rst_n = 1'b0;
    clr   = 2'b01;
    tick();
    checks++; if (en !== 2'b00 || tripped !== 2'b00 || locked !== 2'b00 || fault_any !== 1'b0)
    begin
      $display("FAIL reset_in_lock: got en=%b tripped=%b locked=%b fault=%b want all 0",
               en, tripped, locked, fault_any);
      errors++; end
    rst_n = 1'b1;
    oc    = 2'b00;
    clr   = 2'b00;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++; if (locked[0] !== 1'b0 || tripped[0] !== 1'b0) begin
        $display("FAIL post_reset_state cyc %0d: got locked=%b tripped=%b want 0 0",
                 k, locked[0], tripped[0]);
        errors++; end
      checks++; if (en[0] !== on0 || en[1] !== on1) begin
        $display("FAIL post_reset_en cyc %0d: got %b%b want %b%b", k, en[1], en[0], on1, on0);
        errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_duty_max();
    test_short_pulse();
    test_trip();
    test_retry_clear();
    test_lock();
    test_reset_in_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
